block_words: RTL and testbench

- Serialiser: accepts one 128-bit block on a valid/ready handshake and emits it as four 32-bit words on a second valid/ready handshake, least-significant word first.
- Sits downstream of the block cipher datapath and feeds word-wide sinks such as the bus/FIFO interface.
- Inverse of the word-to-block packer.
- Sustains one word per cycle across back-to-back blocks with no bubble.

---
 rtl/block_words.sv | 77 +++++++
 tb/tb_block_words.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_words.sv
// block_words: 128-bit block to 32-bit word serialiser (least-significant word first).
// A block is taken on the block_valid/block_ready handshake and then emitted one word
// per word_valid/word_ready handshake. A new block may load on the same edge that the
// last word of the current block leaves, so back-to-back blocks stream with no bubble.
// Optional build macro BLOCK_WORDS_LAST_EN adds the word_last output.
module block_words #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned WORDS  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     block_valid,
  output logic                     block_ready,
  input  logic [WORD_W*WORDS-1:0]  block,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic [WORD_W-1:0]        word
`ifdef BLOCK_WORDS_LAST_EN
  ,
  output logic                     word_last
`endif
);

  localparam int unsigned      IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  logic [WORD_W*WORDS-1:0] data_q;
  logic [IDX_W-1:0]        idx;
  logic                    full;
  logic                    at_last;
  logic                    word_fire;
  logic                    block_fire;
  logic [WORD_W-1:0]       words [WORDS];

  // Word view of the block register; data_q is cleared when empty, so word reads 0 then.
  for (genvar g = 0; g < WORDS; g++) begin : g_words
    assign words[g] = data_q[g*WORD_W +: WORD_W];
  end

  assign at_last     = (idx == LAST_IDX);
  assign word_fire   = full && word_ready;
  // Ready while empty, or while the final word is leaving this cycle.
  assign block_ready = !full || (word_ready && at_last);
  assign block_fire  = block_valid && block_ready;
  assign word_valid  = full;

`ifdef BLOCK_WORDS_LAST_EN
  assign word_last = full && at_last;
`endif

  // Output word mux selected by the current index.
  always_comb begin
    word = words[idx];
  end

  // Block load takes priority; otherwise advance or retire on each word handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      idx    <= '0;
      full   <= 1'b0;
    end else if (block_fire) begin
      data_q <= block;
      idx    <= '0;
      full   <= 1'b1;
    end else if (word_fire) begin
      if (at_last) begin
        data_q <= '0;
        idx    <= '0;
        full   <= 1'b0;
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_block_words.sv
// tb_block_words: self-checking bench for block_words against a word-queue reference model.
module tb_block_words;

  localparam int W = 32;
  localparam int N = 4;
  localparam logic [W*N-1:0] BLK_A = 128'hF9F9F9F9A0A0A0A089ABCDEF01234567;
  localparam logic [W*N-1:0] BLK_B = 128'hE8E8E8E8B1B1B1B1FEDCBA9876543210;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           block_valid = 1'b0;
  logic           word_ready = 1'b0;
  logic [W*N-1:0] block = '0;
  logic           block_ready;
  logic           word_valid;
  logic [W-1:0]   word;
`ifdef BLOCK_WORDS_LAST_EN
  logic           word_last;
`endif

  int tests = 0;
  int fails = 0;

  // Words still owed downstream, oldest first.
  logic [W-1:0] q[$];
  logic         m_rdy;

  block_words #(.WORD_W(W), .WORDS(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .block       (block),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .word        (word)
`ifdef BLOCK_WORDS_LAST_EN
    ,
    .word_last   (word_last)
`endif
  );

  always #5 clk = ~clk;

  // Reference: a block may enter only when the queue is empty or its final word is leaving.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      m_rdy = (q.size() == 0) || (word_ready && q.size() == 1);
      if (q.size() != 0 && word_ready) void'(q.pop_front());
      if (block_valid && m_rdy)
        for (int i = 0; i < N; i++) q.push_back(block[i*W +: W]);
    end
  end

  function automatic logic exp_valid();
    return q.size() != 0;
  endfunction

  function automatic logic exp_ready();
    return (q.size() == 0) || (word_ready && q.size() == 1);
  endfunction

  function automatic logic [W-1:0] exp_word();
    return (q.size() != 0) ? q[0] : '0;
  endfunction

  function automatic logic exp_last();
    return q.size() == 1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; block_valid = 1'b0; word_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({word_valid, block_ready, word} !== {1'b0, 1'b1, 32'h0}) begin
      fails++;
      $display("FAIL reset got v=%b r=%b w=%h exp v=0 r=1 w=00000000", word_valid, block_ready, word);
    end
`ifdef BLOCK_WORDS_LAST_EN
    tests++;
    if (word_last !== 1'b0) begin
      fails++; $display("FAIL reset_last got %b exp 0", word_last);
    end
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [W*N-1:0] pend[$];
    logic [W-1:0]   got[$];
    int             gcyc[$];
    logic           acc;
    logic [W-1:0]   ew [4] = '{32'h01234567, 32'h89ABCDEF, 32'hA0A0A0A0, 32'hF9F9F9F9};
    pend.push_back(BLK_A);
    for (int c = 0; c < 8; c++) begin
      word_ready = 1'b1;
      block_valid = pend.size() != 0;
      block = block_valid ? pend[0] : '0;
      @(negedge clk);
      tests++;
      if ({word_valid, block_ready, word} !== {exp_valid(), exp_ready(), exp_word()}) begin
        fails++;
        $display("FAIL single c=%0d got v=%b r=%b w=%h exp v=%b r=%b w=%h", c,
                 word_valid, block_ready, word, exp_valid(), exp_ready(), exp_word());
      end
`ifdef BLOCK_WORDS_LAST_EN
      tests++;
      if (word_last !== exp_last()) begin
        fails++; $display("FAIL single_last c=%0d got %b exp %b", c, word_last, exp_last());
      end
`endif
      acc = block_valid && exp_ready();
      if (word_valid && word_ready) begin got.push_back(word); gcyc.push_back(c); end
      @(posedge clk); #1;
      if (acc) void'(pend.pop_front());
    end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (got.size() <= k || got[k] !== ew[k] || gcyc[k] != 1 + k) begin
        fails++;
        $display("FAIL single_order k=%0d got %h@%0d exp %h@%0d", k, got[k], gcyc[k], ew[k], 1 + k);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W*N-1:0] pend[$];
    logic [W-1:0]   got[$];
    int             gcyc[$];
    logic           acc;
    logic [W-1:0]   ew [8] = '{32'h01234567, 32'h89ABCDEF, 32'hA0A0A0A0, 32'hF9F9F9F9,
                               32'h76543210, 32'hFEDCBA98, 32'hB1B1B1B1, 32'hE8E8E8E8};
    pend.push_back(BLK_A);
    pend.push_back(BLK_B);
    for (int c = 0; c < 11; c++) begin
      word_ready = 1'b1;
      block_valid = pend.size() != 0;
      block = block_valid ? pend[0] : '0;
      @(negedge clk);
      tests++;
      if ({word_valid, block_ready, word} !== {exp_valid(), exp_ready(), exp_word()}) begin
        fails++;
        $display("FAIL b2b c=%0d got v=%b r=%b w=%h exp v=%b r=%b w=%h", c,
                 word_valid, block_ready, word, exp_valid(), exp_ready(), exp_word());
      end
      acc = block_valid && exp_ready();
      if (word_valid && word_ready) begin got.push_back(word); gcyc.push_back(c); end
      @(posedge clk); #1;
      if (acc) void'(pend.pop_front());
    end
    for (int k = 0; k < 8; k++) begin
      tests++;
      if (got.size() <= k || got[k] !== ew[k] || gcyc[k] != 1 + k) begin
        fails++;
        $display("FAIL b2b_order k=%0d got %h@%0d exp %h@%0d", k, got[k], gcyc[k], ew[k], 1 + k);
      end
    end
  endtask

  task automatic test_stall();
    logic [W*N-1:0] pend[$];
    logic [W-1:0]   got[$];
    logic           acc;
    logic           rp [12] = '{1, 1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1};
    logic [W-1:0]   ew [4] = '{32'h01234567, 32'h89ABCDEF, 32'hA0A0A0A0, 32'hF9F9F9F9};
    pend.push_back(BLK_A);
    for (int c = 0; c < 12; c++) begin
      word_ready = rp[c];
      block_valid = pend.size() != 0;
      block = block_valid ? pend[0] : '0;
      @(negedge clk);
      tests++;
      if ({word_valid, block_ready, word} !== {exp_valid(), exp_ready(), exp_word()}) begin
        fails++;
        $display("FAIL stall c=%0d got v=%b r=%b w=%h exp v=%b r=%b w=%h", c,
                 word_valid, block_ready, word, exp_valid(), exp_ready(), exp_word());
      end
`ifdef BLOCK_WORDS_LAST_EN
      tests++;
      if (word_last !== exp_last()) begin
        fails++; $display("FAIL stall_last c=%0d got %b exp %b", c, word_last, exp_last());
      end
`endif
      acc = block_valid && exp_ready();
      if (word_valid && word_ready) got.push_back(word);
      @(posedge clk); #1;
      if (acc) void'(pend.pop_front());
    end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (got.size() <= k || got[k] !== ew[k]) begin
        fails++; $display("FAIL stall_order k=%0d got %h exp %h", k, got[k], ew[k]);
      end
    end
  endtask

  task automatic test_hold_new_block();
    logic [W*N-1:0] pend[$];
    logic [W-1:0]   got[$];
    int             acc_cyc[$];
    logic           acc;
    logic           rp [14] = '{0, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    pend.push_back(BLK_A);
    pend.push_back(BLK_B);
    for (int c = 0; c < 14; c++) begin
      word_ready = rp[c];
      block_valid = pend.size() != 0;
      block = block_valid ? pend[0] : '0;
      @(negedge clk);
      tests++;
      if ({word_valid, block_ready, word} !== {exp_valid(), exp_ready(), exp_word()}) begin
        fails++;
        $display("FAIL hold c=%0d got v=%b r=%b w=%h exp v=%b r=%b w=%h", c,
                 word_valid, block_ready, word, exp_valid(), exp_ready(), exp_word());
      end
      acc = block_valid && exp_ready();
      if (acc) acc_cyc.push_back(c);
      if (word_valid && word_ready) got.push_back(word);
      @(posedge clk); #1;
      if (acc) void'(pend.pop_front());
    end
    // Word 0 leaves at cycle 1, stalls at idx 1 over cycles 2-4, final word leaves at cycle 7.
    tests++;
    if (acc_cyc.size() != 2 || acc_cyc[1] != 7) begin
      fails++; $display("FAIL hold_accept_cycle got %0d exp 7", acc_cyc.size() > 1 ? acc_cyc[1] : -1);
    end
    tests++;
    if (got.size() != 8 || got[3] !== 32'hF9F9F9F9 || got[4] !== 32'h76543210) begin
      fails++; $display("FAIL hold_order got n=%0d w3=%h w4=%h exp n=8 w3=f9f9f9f9 w4=76543210",
                        got.size(), got[3], got[4]);
    end
  endtask

  task automatic test_reset_mid();
    logic [W*N-1:0] pend[$];
    logic [W-1:0]   got[$];
    logic           acc;
    pend.push_back(BLK_A);
    for (int c = 0; c < 3; c++) begin
      word_ready = 1'b1;
      block_valid = pend.size() != 0;
      block = block_valid ? pend[0] : '0;
      @(negedge clk);
      acc = block_valid && exp_ready();
      @(posedge clk); #1;
      if (acc) void'(pend.pop_front());
    end
    block_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({word_valid, block_ready, word} !== {1'b0, 1'b1, 32'h0}) begin
      fails++;
      $display("FAIL reset_mid got v=%b r=%b w=%h exp v=0 r=1 w=00000000", word_valid, block_ready, word);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if (word_valid !== 1'b0) begin
        fails++; $display("FAIL reset_idle c=%0d got v=%b exp v=0", c, word_valid);
      end
      @(posedge clk); #1;
    end
    pend.push_back(BLK_B);
    for (int c = 0; c < 6; c++) begin
      block_valid = pend.size() != 0;
      block = block_valid ? pend[0] : '0;
      @(negedge clk);
      tests++;
      if ({word_valid, block_ready, word} !== {exp_valid(), exp_ready(), exp_word()}) begin
        fails++;
        $display("FAIL reset_next c=%0d got v=%b r=%b w=%h exp v=%b r=%b w=%h", c,
                 word_valid, block_ready, word, exp_valid(), exp_ready(), exp_word());
      end
      acc = block_valid && exp_ready();
      if (word_valid && word_ready) got.push_back(word);
      @(posedge clk); #1;
      if (acc) void'(pend.pop_front());
    end
    tests++;
    if (got.size() != 4 || got[0] !== 32'h76543210) begin
      fails++; $display("FAIL reset_next_first got n=%0d w=%h exp n=4 w=76543210", got.size(), got[0]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      block_valid = ($urandom_range(0, 3) != 0);
      block = {$urandom, $urandom, $urandom, $urandom};
      word_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      tests++;
      if ({word_valid, block_ready, word} !== {exp_valid(), exp_ready(), exp_word()}) begin
        fails++;
        $display("FAIL random c=%0d got v=%b r=%b w=%h exp v=%b r=%b w=%h", c,
                 word_valid, block_ready, word, exp_valid(), exp_ready(), exp_word());
      end
`ifdef BLOCK_WORDS_LAST_EN
      tests++;
      if (word_last !== exp_last()) begin
        fails++; $display("FAIL random_last c=%0d got %b exp %b", c, word_last, exp_last());
      end
`endif
      @(posedge clk); #1;
    end
    block_valid = 1'b0;
    word_ready = 1'b1;
    repeat (N + 1) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_hold_new_block();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
